// File: rtl/vehicle_gate_sensor.sv
// Gate front end: synchronizes and debounces the two optical beams, then
// classifies complete car passages into single-cycle entrance/exit pulses.
module vehicle_gate_sensor #(
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic sensorA,
  input  logic sensorB,
  input  logic isFull,
  output logic entrance_gate,
  output logic exit_gate,
  output logic gateOpen,
  output logic denied,
  output logic fault
);

  // state  | meaning
  // IDLE   | no passage in progress
  // IN_A   | entry started, outer beam only
  // IN_AB  | entry, both beams blocked
  // IN_B   | entry, inner beam only
  // OUT_B  | exit started, inner beam only
  // OUT_AB | exit, both beams blocked
  // OUT_A  | exit, outer beam only
  // DENY   | entry refused (lot full), waiting for beams to clear
  typedef enum logic [2:0] {IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A, DENY} stateT;

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [1:0]    syncRegA, syncRegB;
  logic [1:0]    syncAB;
  logic [1:0]    debAB;
  logic [DW-1:0] debCnt [2];
  logic [TW-1:0] tCnt;
  stateT         state, nextState;
  logic          timedOut;
  logic          nextEnt, nextExit, nextDen, nextFault;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncRegA <= '0;
      syncRegB <= '0;
    end else begin
      syncRegA <= {syncRegA[0], sensorA};
      syncRegB <= {syncRegB[0], sensorB};
    end
  end

  assign syncAB = {syncRegA[1], syncRegB[1]};

  // bit 1 is beam A, bit 0 is beam B throughout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      debAB     <= '0;
      debCnt[0] <= '0;
      debCnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (syncAB[i] == debAB[i]) begin
          debCnt[i] <= '0;
        end else if (debCnt[i] == DEB_LAST) begin
          debAB[i]  <= syncAB[i];
          debCnt[i] <= '0;
        end else begin
          debCnt[i] <= debCnt[i] + DW'(1);
        end
      end
    end
  end

  assign timedOut = (state != IDLE) && (tCnt == TMO_LAST);

  always_comb begin
    nextState = state;
    nextEnt   = 1'b0;
    nextExit  = 1'b0;
    nextDen   = 1'b0;
    nextFault = 1'b0;
    if (timedOut) begin
      nextState = IDLE;
      nextFault = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          case (debAB)
            2'b10: begin
              if (isFull) begin
                nextState = DENY;
                nextDen   = 1'b1;
              end else begin
                nextState = IN_A;
              end
            end
            2'b01:   nextState = OUT_B;
            2'b11:   nextFault = 1'b1;
            default: nextState = IDLE;
          endcase
        end
        IN_A: begin
          case (debAB)
            2'b11:   nextState = IN_AB;
            2'b00:   nextState = IDLE;
            2'b01:   begin nextState = IDLE; nextFault = 1'b1; end
            default: nextState = IN_A;
          endcase
        end
        IN_AB: begin
          case (debAB)
            2'b01:   nextState = IN_B;
            2'b10:   nextState = IN_A;
            2'b00:   begin nextState = IDLE; nextFault = 1'b1; end
            default: nextState = IN_AB;
          endcase
        end
        IN_B: begin
          case (debAB)
            2'b00:   begin nextState = IDLE; nextEnt = 1'b1; end
            2'b11:   nextState = IN_AB;
            2'b10:   begin nextState = IDLE; nextFault = 1'b1; end
            default: nextState = IN_B;
          endcase
        end
        OUT_B: begin
          case (debAB)
            2'b11:   nextState = OUT_AB;
            2'b00:   nextState = IDLE;
            2'b10:   begin nextState = IDLE; nextFault = 1'b1; end
            default: nextState = OUT_B;
          endcase
        end
        OUT_AB: begin
          case (debAB)
            2'b10:   nextState = OUT_A;
            2'b01:   nextState = OUT_B;
            2'b00:   begin nextState = IDLE; nextFault = 1'b1; end
            default: nextState = OUT_AB;
          endcase
        end
        OUT_A: begin
          case (debAB)
            2'b00:   begin nextState = IDLE; nextExit = 1'b1; end
            2'b11:   nextState = OUT_AB;
            2'b01:   begin nextState = IDLE; nextFault = 1'b1; end
            default: nextState = OUT_A;
          endcase
        end
        DENY: begin
          if (debAB == 2'b00) nextState = IDLE;
        end
        default: nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      tCnt          <= '0;
      entrance_gate <= 1'b0;
      exit_gate     <= 1'b0;
      gateOpen      <= 1'b0;
      denied        <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state <= nextState;
      if ((nextState != state) || (state == IDLE)) tCnt <= '0;
      else                                         tCnt <= tCnt + TW'(1);
      entrance_gate <= nextEnt;
      exit_gate     <= nextExit;
      denied        <= nextDen;
      fault         <= nextFault;
      gateOpen      <= (nextState == IN_A) || (nextState == IN_AB) || (nextState == IN_B);
    end
  end

endmodule

// File: tb/tb_vehicle_gate_sensor.sv
// Bench for vehicle_gate_sensor: directed passages plus random beam traffic,
// each cycle checked against a path-based reference model of the gate.
module tb_vehicle_gate_sensor;
  localparam int DEB = 2;
  localparam int TMO = 16;
  localparam int EV_NONE = 0, EV_ENT = 1, EV_EXIT = 2, EV_DEN = 3, EV_FAULT = 4;
  localparam int D_IDLE = 0, D_IN = 1, D_OUT = 2, D_DENY = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sensorA = 1'b0, sensorB = 1'b0, isFull = 1'b0;
  logic entrance_gate, exit_gate, gateOpen, denied, fault;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vehicle_gate_sensor #(.DEBOUNCE(DEB), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .sensorA(sensorA), .sensorB(sensorB), .isFull(isFull),
    .entrance_gate(entrance_gate), .exit_gate(exit_gate), .gateOpen(gateOpen),
    .denied(denied), .fault(fault)
  );

  // Reference model: raw/sync history queues, debounced levels, and a passage
  // described as a direction plus a position along its three-pattern path.
  bit rawQA[$], rawQB[$], syncQA[$], syncQB[$];
  bit debA, debB;
  int dir, step, edgeNum, enteredAt;
  logic [4:0] expV;

  int cyc, nEnt, nExit, nDen, nFault, nOpen;
  int firstEnt, firstExit, firstDen, firstFault, firstOpen;

  function automatic logic [1:0] pathAt(int d, int s);
    logic [1:0] inPath [3];
    logic [1:0] outPath [3];
    inPath  = '{2'b10, 2'b11, 2'b01};
    outPath = '{2'b01, 2'b11, 2'b10};
    return (d == D_IN) ? inPath[s] : outPath[s];
  endfunction

  task automatic modelReset();
    rawQA.delete(); rawQB.delete(); syncQA.delete(); syncQB.delete();
    debA = 0; debB = 0; dir = D_IDLE; step = 0; enteredAt = edgeNum;
  endtask

  task automatic modelEdge(input bit a, input bit b, input bit full);
    bit sa, sb, diffA, diffB;
    logic [1:0] ab;
    int nd, ns, ev;
    edgeNum++;
    sa = (rawQA.size() >= 2) ? rawQA[rawQA.size()-2] : 1'b0;
    sb = (rawQB.size() >= 2) ? rawQB[rawQB.size()-2] : 1'b0;
    rawQA.push_back(a); rawQB.push_back(b);
    if (rawQA.size() > 4) begin rawQA.delete(0); rawQB.delete(0); end
    ab = {debA, debB};
    nd = dir; ns = step; ev = EV_NONE;
    if (dir != D_IDLE && (edgeNum - enteredAt) >= TMO) begin
      nd = D_IDLE; ns = 0; ev = EV_FAULT;
    end else if (dir == D_IDLE) begin
      if (ab == 2'b10) begin
        if (full) begin nd = D_DENY; ev = EV_DEN; end
        else begin nd = D_IN; ns = 0; end
      end else if (ab == 2'b01) begin
        nd = D_OUT; ns = 0;
      end else if (ab == 2'b11) begin
        ev = EV_FAULT;
      end
    end else if (dir == D_DENY) begin
      if (ab == 2'b00) nd = D_IDLE;
    end else begin
      if (ab == pathAt(dir, step)) begin
        ns = step;
      end else if (step < 2 && ab == pathAt(dir, step + 1)) begin
        ns = step + 1;
      end else if (step > 0 && ab == pathAt(dir, step - 1)) begin
        ns = step - 1;
      end else if (ab == 2'b00) begin
        nd = D_IDLE; ns = 0;
        if (step == 2) ev = (dir == D_IN) ? EV_ENT : EV_EXIT;
        else if (step == 1) ev = EV_FAULT;
      end else begin
        nd = D_IDLE; ns = 0; ev = EV_FAULT;
      end
    end
    if (nd != dir || ns != step) enteredAt = edgeNum;
    dir = nd; step = ns;
    expV = {ev == EV_ENT, ev == EV_EXIT, nd == D_IN, ev == EV_DEN, ev == EV_FAULT};
    // a debounced level flips once DEB successive sync samples all disagree with it
    syncQA.push_back(sa); syncQB.push_back(sb);
    if (syncQA.size() > DEB) begin syncQA.delete(0); syncQB.delete(0); end
    if (syncQA.size() == DEB) begin
      diffA = 1; diffB = 1;
      foreach (syncQA[k]) begin
        if (syncQA[k] == debA) diffA = 0;
        if (syncQB[k] == debB) diffB = 0;
      end
      if (diffA) debA = ~debA;
      if (diffB) debB = ~debB;
    end
  endtask

  task automatic clearStats();
    cyc = 0; nEnt = 0; nExit = 0; nDen = 0; nFault = 0; nOpen = 0;
    firstEnt = -1; firstExit = -1; firstDen = -1; firstFault = -1; firstOpen = -1;
  endtask

  task automatic cycle(input bit a, input bit b, input bit full);
    logic [4:0] obs;
    sensorA = a; sensorB = b; isFull = full;
    @(posedge clk); #1;
    modelEdge(a, b, full);
    obs = {entrance_gate, exit_gate, gateOpen, denied, fault};
    vectors++;
    if (obs !== expV) begin
      miscompares++;
      $display("FAIL cycle_outputs t=%0t {ent,exit,open,den,fault} got %b expected %b", $time, obs, expV);
    end
    cyc++;
    if (entrance_gate === 1'b1) begin nEnt++;   if (firstEnt   < 0) firstEnt   = cyc; end
    if (exit_gate     === 1'b1) begin nExit++;  if (firstExit  < 0) firstExit  = cyc; end
    if (denied        === 1'b1) begin nDen++;   if (firstDen   < 0) firstDen   = cyc; end
    if (fault         === 1'b1) begin nFault++; if (firstFault < 0) firstFault = cyc; end
    if (gateOpen      === 1'b1) begin nOpen++;  if (firstOpen  < 0) firstOpen  = cyc; end
  endtask

  task automatic hold(input bit a, input bit b, input bit full, input int n);
    for (int i = 0; i < n; i++) cycle(a, b, full);
  endtask

  task automatic test_reset;
    reset = 1; sensorA = 0; sensorB = 0; isFull = 0;
    repeat (3) @(posedge clk);
    #1;
    edgeNum = 0;
    modelReset();
    vectors++;
    if ({entrance_gate, exit_gate, gateOpen, denied, fault} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b expected 00000", {entrance_gate, exit_gate, gateOpen, denied, fault});
    end
    reset = 0;
    clearStats();
    hold(0, 0, 0, 4);
  endtask

  task automatic test_entry;
    clearStats();
    hold(0, 0, 0, 4); hold(1, 0, 0, 6); hold(1, 1, 0, 6); hold(0, 1, 0, 6); hold(0, 0, 0, 8);
    vectors++;
    if (nEnt !== 1 || firstEnt !== 27) begin
      miscompares++;
      $display("FAIL entry_pulse count=%0d at=%0d expected count=1 at=27", nEnt, firstEnt);
    end
    vectors++;
    if (firstOpen !== 9 || nExit + nDen + nFault !== 0) begin
      miscompares++;
      $display("FAIL entry_side open_at=%0d other_pulses=%0d expected open_at=9 other_pulses=0", firstOpen, nExit + nDen + nFault);
    end
  endtask

  task automatic test_exit;
    clearStats();
    hold(0, 0, 0, 4); hold(0, 1, 0, 6); hold(1, 1, 0, 6); hold(1, 0, 0, 6); hold(0, 0, 0, 8);
    vectors++;
    if (nExit !== 1 || firstExit !== 27) begin
      miscompares++;
      $display("FAIL exit_pulse count=%0d at=%0d expected count=1 at=27", nExit, firstExit);
    end
    vectors++;
    if (nOpen !== 0 || nEnt + nDen + nFault !== 0) begin
      miscompares++;
      $display("FAIL exit_side open_cycles=%0d other_pulses=%0d expected 0 and 0", nOpen, nEnt + nDen + nFault);
    end
  endtask

  task automatic test_full_lot;
    clearStats();
    hold(0, 0, 1, 4); hold(1, 0, 1, 4); hold(1, 1, 1, 4); hold(0, 1, 1, 4); hold(0, 0, 1, 8);
    vectors++;
    if (nDen !== 1 || firstDen !== 9) begin
      miscompares++;
      $display("FAIL full_denied count=%0d at=%0d expected count=1 at=9", nDen, firstDen);
    end
    vectors++;
    if (nEnt + nExit + nFault + nOpen !== 0) begin
      miscompares++;
      $display("FAIL full_side other_activity=%0d expected 0", nEnt + nExit + nFault + nOpen);
    end
  endtask

  task automatic test_backout;
    clearStats();
    hold(0, 0, 0, 4); hold(1, 0, 0, 6); hold(1, 1, 0, 6); hold(1, 0, 0, 6); hold(0, 0, 0, 8);
    vectors++;
    if (nEnt + nExit + nDen + nFault !== 0 || nOpen === 0 || gateOpen !== 1'b0) begin
      miscompares++;
      $display("FAIL backout pulses=%0d open_cycles=%0d final_open=%b expected 0, >0, 0",
               nEnt + nExit + nDen + nFault, nOpen, gateOpen);
    end
  endtask

  task automatic test_glitch;
    clearStats();
    hold(0, 0, 0, 4); hold(1, 0, 0, 1); hold(0, 0, 0, 8);
    vectors++;
    if (nEnt + nExit + nDen + nFault + nOpen !== 0) begin
      miscompares++;
      $display("FAIL glitch activity=%0d expected 0", nEnt + nExit + nDen + nFault + nOpen);
    end
  endtask

  task automatic test_illegal;
    clearStats();
    hold(0, 0, 0, 4); hold(1, 1, 0, 6); hold(0, 0, 0, 8);
    // IDLE flags every cycle that the debounced pair stays 11
    vectors++;
    if (firstFault !== 9 || nFault !== 6) begin
      miscompares++;
      $display("FAIL illegal_fault at=%0d count=%0d expected at=9 count=6", firstFault, nFault);
    end
    vectors++;
    if (nEnt + nExit + nDen + nOpen !== 0) begin
      miscompares++;
      $display("FAIL illegal_side activity=%0d expected 0", nEnt + nExit + nDen + nOpen);
    end
  endtask

  task automatic test_timeout;
    clearStats();
    hold(0, 0, 0, 4);
    for (int i = 0; i < 30; i++) begin
      cycle(1, 0, 0);
      if (cyc == 25) begin
        vectors++;
        if (fault !== 1'b1 || gateOpen !== 1'b0) begin
          miscompares++;
          $display("FAIL timeout_abort fault=%b open=%b expected fault=1 open=0", fault, gateOpen);
        end
      end
      if (cyc == 26) begin
        vectors++;
        if (gateOpen !== 1'b1) begin
          miscompares++;
          $display("FAIL timeout_reentry open=%b expected 1", gateOpen);
        end
      end
    end
    vectors++;
    if (firstOpen !== 9 || firstFault !== 25 || nFault !== 1) begin
      miscompares++;
      $display("FAIL timeout_timing open_at=%0d fault_at=%0d faults=%0d expected 9, 25, 1", firstOpen, firstFault, nFault);
    end
    hold(0, 0, 0, 8);
  endtask

  task automatic test_reset_mid;
    clearStats();
    hold(0, 0, 0, 4); hold(1, 0, 0, 6); hold(1, 1, 0, 6);
    vectors++;
    if (gateOpen !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_pre open=%b expected 1", gateOpen);
    end
    #2 reset = 1;
    #1;
    modelReset();
    vectors++;
    if ({entrance_gate, exit_gate, gateOpen, denied, fault} !== 5'b0) begin
      miscompares++;
      $display("FAIL midreset_async got %b expected 00000", {entrance_gate, exit_gate, gateOpen, denied, fault});
    end
    repeat (2) begin
      @(posedge clk); #1;
      vectors++;
      if ({entrance_gate, exit_gate, gateOpen, denied, fault} !== 5'b0) begin
        miscompares++;
        $display("FAIL midreset_hold got %b expected 00000", {entrance_gate, exit_gate, gateOpen, denied, fault});
      end
    end
    reset = 0;
    clearStats();
    hold(0, 1, 0, 6); hold(0, 0, 0, 8);
    vectors++;
    if (nEnt !== 0 || nOpen !== 0) begin
      miscompares++;
      $display("FAIL midreset_after ent=%0d open_cycles=%0d expected 0 and 0", nEnt, nOpen);
    end
  endtask

  task automatic test_random;
    logic [1:0] ab;
    int len, r;
    bit full;
    clearStats();
    for (int s = 0; s < 80; s++) begin
      r    = $urandom_range(0, 9);
      ab   = 2'($urandom_range(0, 3));
      full = ($urandom_range(0, 3) == 0);
      len  = (r == 0) ? 1 : (r == 1) ? 20 : $urandom_range(2, 9);
      hold(ab[1], ab[0], full, len);
    end
    hold(0, 0, 0, 30);
  endtask

  initial begin
    edgeNum = 0;
    modelReset();
    clearStats();
    test_reset;
    test_entry;
    test_exit;
    test_full_lot;
    test_backout;
    test_glitch;
    test_illegal;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
